// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 32;
  localparam int unsigned FIB_CNT_W = 16;

  localparam int unsigned FIB_F0 = 0;
  localparam int unsigned FIB_F1 = 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone,
    StError
  } fib_chk_state_t;

endpackage

// File: rtl/fib_stream_checker_if.sv
// Valid/ready term stream from the generator into the checker.
interface fib_stream_checker_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fib_ref_gen.sv
// Reference Fibonacci generator; the sum is formed one bit wider so the carry flags overflow.
module fib_ref_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_ref,
  output logic             o_carry,
  output logic [CNT_W-1:0] o_index
);

  logic [WIDTH-1:0] r_prev1;
  logic [WIDTH-1:0] r_prev2;
  logic [CNT_W-1:0] r_index;
  logic [WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_prev1} + {1'b0, r_prev2};
  assign o_index = r_index;

  // Indices 0 and 1 are seeds; only later terms can carry out.
  always_comb begin
    o_ref   = w_sum[WIDTH-1:0];
    o_carry = w_sum[WIDTH];
    if (r_index == CNT_W'(0)) begin
      o_ref   = WIDTH'(FIB_F0);
      o_carry = 1'b0;
    end else if (r_index == CNT_W'(1)) begin
      o_ref   = WIDTH'(FIB_F1);
      o_carry = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev1 <= '0;
      r_prev2 <= '0;
      r_index <= '0;
    end else if (i_clear) begin
      r_prev1 <= '0;
      r_prev2 <= '0;
      r_index <= '0;
    end else if (i_advance) begin
      r_prev2 <= r_prev1;
      r_prev1 <= o_ref;
      r_index <= r_index + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fib_stream_checker.sv
// Scoreboard stage: checks an incoming Fibonacci term stream against a local reference.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned CNT_W = FIB_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_size,
  fib_stream_checker_if.slave  s_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_overflow,
  output logic [CNT_W-1:0]     o_err_index,
  output logic [WIDTH-1:0]     o_expected,
  output logic [CNT_W-1:0]     o_term_count
);

  fib_chk_state_t   r_state;
  fib_chk_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_size;
  logic [CNT_W-1:0] w_size_nxt;
  logic [CNT_W-1:0] r_term_count;
  logic [CNT_W-1:0] w_term_count_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_error;
  logic             w_error_nxt;
  logic             r_overflow;
  logic             w_overflow_nxt;
  logic [CNT_W-1:0] r_err_index;
  logic [CNT_W-1:0] w_err_index_nxt;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] w_expected_nxt;

  logic             w_run;
  logic             w_accept;
  logic [CNT_W-1:0] w_term_inc;
  logic             w_ref_clear;
  logic             w_ref_advance;
  logic [WIDTH-1:0] w_ref;
  logic             w_ref_carry;
  logic [CNT_W-1:0] w_ref_index;

  fib_ref_gen #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ref_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_ref_clear),
    .i_advance (w_ref_advance),
    .o_ref     (w_ref),
    .o_carry   (w_ref_carry),
    .o_index   (w_ref_index)
  );

  // Ready decodes only the registered state, never in_valid.
  assign w_run      = (r_state == StRun);
  assign w_accept   = s_in.valid && w_run;
  assign w_term_inc = r_term_count + CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_size_nxt       = r_size;
    w_term_count_nxt = r_term_count;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
    w_overflow_nxt   = r_overflow;
    w_err_index_nxt  = r_err_index;
    w_expected_nxt   = r_expected;
    w_ref_clear      = 1'b0;
    w_ref_advance    = 1'b0;

    unique case (r_state)
      StRun: begin
        if (w_accept) begin
          if (w_ref_carry) begin
            w_overflow_nxt  = 1'b1;
            w_error_nxt     = 1'b1;
            w_err_index_nxt = w_ref_index;
            w_expected_nxt  = w_ref;
            w_state_nxt     = StError;
          end else if (s_in.data != w_ref) begin
            w_error_nxt     = 1'b1;
            w_err_index_nxt = w_ref_index;
            w_expected_nxt  = w_ref;
            w_state_nxt     = StError;
          end else begin
            w_term_count_nxt = w_term_inc;
            w_ref_advance    = 1'b1;
            if (w_term_inc == r_size) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = StDone;
            end
          end
        end
      end
      StIdle, StDone, StError: begin
        if (i_start) begin
          w_size_nxt       = i_size;
          w_term_count_nxt = '0;
          w_error_nxt      = 1'b0;
          w_overflow_nxt   = 1'b0;
          w_err_index_nxt  = '0;
          w_expected_nxt   = '0;
          w_ref_clear      = 1'b1;
          if (i_size == CNT_W'(0)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_done_nxt  = 1'b0;
            w_state_nxt = StRun;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_size       <= '0;
      r_term_count <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_overflow   <= 1'b0;
      r_err_index  <= '0;
      r_expected   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_size       <= w_size_nxt;
      r_term_count <= w_term_count_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_overflow   <= w_overflow_nxt;
      r_err_index  <= w_err_index_nxt;
      r_expected   <= w_expected_nxt;
    end
  end

  assign s_in.ready   = w_run;
  assign o_busy       = w_run;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_overflow   = r_overflow;
  assign o_err_index  = r_err_index;
  assign o_expected   = r_expected;
  assign o_term_count = r_term_count;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed bench for fib_stream_checker: clean runs, mismatch, overflow, stalls, async reset.
module tb_fib_stream_checker;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_size;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic        o_overflow;
  logic [15:0] o_err_index;
  logic [31:0] o_expected;
  logic [15:0] o_term_count;

  int errors = 0;
  int checks = 0;

  fib_stream_checker_if #(.WIDTH(32)) bus ();

  fib_stream_checker u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_size       (i_size),
    .s_in         (bus),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_overflow   (o_overflow),
    .o_err_index  (o_err_index),
    .o_expected   (o_expected),
    .o_term_count (o_term_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] size);
    @(negedge clk);
    bus.valid = 1'b0;
    i_start   = 1'b1;
    i_size    = size;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  // Drive one term; waits (bounded) until it is accepted on a rising edge.
  task automatic send(input logic [31:0] v, input bit gap, input bit pulse);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    if (gap) begin
      bus.valid = 1'b0;
      @(negedge clk);
    end
    bus.valid = 1'b1;
    bus.data  = v;
    if (pulse) begin
      i_start = 1'b1;
      i_size  = 16'd3;
    end
    for (int k = 0; k < 20 && !acc; k++) begin
      if (k > 0) begin
        @(negedge clk);
        i_start = 1'b0;
      end
      acc = bus.ready;
      @(posedge clk);
    end
    chk("beat_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic settle();
    @(negedge clk);
    bus.valid = 1'b0;
    i_start   = 1'b0;
  endtask

  logic [31:0] cur;
  logic [31:0] nxt;
  logic [31:0] tmp;
  logic [31:0] seq10 [10];
  logic [31:0] seq5 [5];

  initial begin
    seq10 = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    seq5  = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd4};
    rst       = 1'b1;
    i_start   = 1'b0;
    i_size    = '0;
    bus.valid = 1'b0;
    bus.data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_term_count", o_term_count, 0);

    // Clean run of 10 terms, valid held high
    do_start(16'd10);
    chk("t1_ready_after_start", bus.ready, 1);
    chk("t1_busy", o_busy, 1);
    for (int i = 0; i < 10; i++) send(seq10[i], 1'b0, 1'b0);
    settle();
    chk("t1_done", o_done, 1);
    chk("t1_term_count", o_term_count, 10);
    chk("t1_error", o_error, 0);
    chk("t1_ready", bus.ready, 0);

    // Mismatch at index 4
    do_start(16'd6);
    chk("t2_done_cleared", o_done, 0);
    for (int i = 0; i < 5; i++) send(seq5[i], 1'b0, 1'b0);
    settle();
    chk("t2_error", o_error, 1);
    chk("t2_err_index", o_err_index, 4);
    chk("t2_expected", o_expected, 3);
    chk("t2_term_count", o_term_count, 4);
    chk("t2_ready", bus.ready, 0);
    chk("t2_overflow", o_overflow, 0);
    chk("t2_done", o_done, 0);

    // Zero-length run
    do_start(16'd0);
    chk("t3_done", o_done, 1);
    chk("t3_ready", bus.ready, 0);
    chk("t3_error_cleared", o_error, 0);
    chk("t3_err_index_cleared", o_err_index, 0);
    chk("t3_term_count", o_term_count, 0);
    bus.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_ready_stays_low", bus.ready, 0);
    chk("t3_term_count_hold", o_term_count, 0);
    bus.valid = 1'b0;

    // Overflow at index 48; the truncated value is sent so only the carry can flag it
    do_start(16'd50);
    cur = 32'd0;
    nxt = 32'd1;
    for (int i = 0; i < 48; i++) begin
      send(cur, 1'b0, 1'b0);
      tmp = cur + nxt;
      cur = nxt;
      nxt = tmp;
    end
    settle();
    chk("t4_pre_term_count", o_term_count, 48);
    chk("t4_pre_error", o_error, 0);
    send(32'd512559680, 1'b0, 1'b0);
    settle();
    chk("t4_overflow", o_overflow, 1);
    chk("t4_error", o_error, 1);
    chk("t4_err_index", o_err_index, 48);
    chk("t4_expected", o_expected, 512559680);
    chk("t4_term_count", o_term_count, 48);
    chk("t4_ready", bus.ready, 0);

    // Stalled run of 8 with a start pulse mid-run
    do_start(16'd8);
    chk("t5_overflow_cleared", o_overflow, 0);
    for (int i = 0; i < 8; i++)
      send(seq10[i], 1'($urandom_range(0, 1)), (i == 3));
    settle();
    chk("t5_done", o_done, 1);
    chk("t5_term_count", o_term_count, 8);
    chk("t5_error", o_error, 0);

    // Restart after DONE
    do_start(16'd3);
    chk("t6_done_cleared", o_done, 0);
    chk("t6_term_count_cleared", o_term_count, 0);
    for (int i = 0; i < 3; i++) send(seq10[i], 1'b0, 1'b0);
    settle();
    chk("t6_done", o_done, 1);
    chk("t6_term_count", o_term_count, 3);

    // Async reset in the middle of a run
    do_start(16'd8);
    for (int i = 0; i < 5; i++) send(seq10[i], 1'b0, 1'b0);
    settle();
    chk("t7_pre_term_count", o_term_count, 5);
    chk("t7_pre_busy", o_busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t7_ready", bus.ready, 0);
    chk("t7_busy", o_busy, 0);
    chk("t7_done", o_done, 0);
    chk("t7_error", o_error, 0);
    chk("t7_overflow", o_overflow, 0);
    chk("t7_term_count", o_term_count, 0);
    chk("t7_err_index", o_err_index, 0);
    chk("t7_expected", o_expected, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t7_idle_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
